// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types and helpers for the register-file port controller.
// Holds the controller state encoding and the depth helper.
package regfile_port_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_e;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/regfile_rd_chan.sv
// One read client channel: handshake, read pending flag,
// write-to-read forwarding and a hold register for back-pressure.
module regfile_rd_chan #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata
);

    logic                  pend;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  accept;
    logic                  stall;
    logic                  hit;

    assign stall     = pend & ~rsp_ready;
    assign req_ready = init_done & ~hold_valid & ~stall;
    assign accept    = req_valid & req_ready;
    assign hit       = mem_we & (mem_waddr == req_addr);
    assign rsp_valid = pend | hold_valid;

    // SRAM reads old data on a same-edge write, so the write is forwarded
    always_comb begin
        rsp_data = mem_rdata;
        unique case (1'b1)
            hold_valid: rsp_data = hold_data;
            fwd:        rsp_data = fwd_data;
            default:    rsp_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            fwd        <= 1'b0;
            fwd_data   <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            pend <= accept;
            if (accept) begin
                fwd      <= hit;
                fwd_data <= mem_wdata;
            end
            if (stall) begin
                hold_valid <= 1'b1;
                hold_data  <= rsp_data;
            end else if (hold_valid && rsp_ready) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Client-side controller for a 2R/1W registered-read SRAM.
// Sweeps the array to INIT_VALUE, then serves one writer and two readers.
module regfile_port_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd0_req_valid,
    output logic                  rd0_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd0_req_addr,
    output logic                  rd0_rsp_valid,
    input  logic                  rd0_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd0_rsp_data,
    input  logic                  rd1_req_valid,
    output logic                  rd1_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd1_req_addr,
    output logic                  rd1_rsp_valid,
    input  logic                  rd1_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd1_rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH-1:0] mem_raddr2,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata2,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    import regfile_port_ctrl_pkg::*;

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_e                state;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= INIT;
                    cnt   <= '0;
                end
                INIT: begin
                    cnt <= cnt + ADDR_WIDTH'(1);
                    if (cnt == LAST) state <= RUN;
                end
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    assign init_done = (state == RUN);
    assign wr_ready  = init_done;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        unique case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = INIT_VALUE;
            end
            RUN:     mem_we = wr_valid;
            default: mem_we = 1'b0;
        endcase
    end

    assign mem_raddr  = rd0_req_addr;
    assign mem_raddr2 = rd1_req_addr;

    regfile_rd_chan #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_done(init_done),
        .req_valid(rd0_req_valid),
        .req_ready(rd0_req_ready),
        .req_addr (rd0_req_addr),
        .rsp_valid(rd0_rsp_valid),
        .rsp_ready(rd0_rsp_ready),
        .rsp_data (rd0_rsp_data),
        .mem_rdata(mem_rdata),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    regfile_rd_chan #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_done(init_done),
        .req_valid(rd1_req_valid),
        .req_ready(rd1_req_ready),
        .req_addr (rd1_req_addr),
        .rsp_valid(rd1_rsp_valid),
        .rsp_ready(rd1_rsp_ready),
        .rsp_data (rd1_rsp_data),
        .mem_rdata(mem_rdata2),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural 2R/1W SRAM.
module tb_regfile_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam logic [DW-1:0] INIT = 32'hDEAD_0000;

    logic          clk;
    logic          rst_n;
    logic          init_done;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd0_req_valid, rd0_req_ready;
    logic [AW-1:0] rd0_req_addr;
    logic          rd0_rsp_valid, rd0_rsp_ready;
    logic [DW-1:0] rd0_rsp_data;
    logic          rd1_req_valid, rd1_req_ready;
    logic [AW-1:0] rd1_req_addr;
    logic          rd1_rsp_valid, rd1_rsp_ready;
    logic [DW-1:0] rd1_rsp_data;
    logic [AW-1:0] mem_raddr, mem_raddr2;
    logic [DW-1:0] mem_rdata, mem_rdata2;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [DW-1:0] mem     [16];
    logic [DW-1:0] exp_mem [16];

    int checks;
    int errors;

    regfile_port_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_VALUE(INIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_done    (init_done),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd0_req_valid(rd0_req_valid),
        .rd0_req_ready(rd0_req_ready),
        .rd0_req_addr (rd0_req_addr),
        .rd0_rsp_valid(rd0_rsp_valid),
        .rd0_rsp_ready(rd0_rsp_ready),
        .rd0_rsp_data (rd0_rsp_data),
        .rd1_req_valid(rd1_req_valid),
        .rd1_req_ready(rd1_req_ready),
        .rd1_req_addr (rd1_req_addr),
        .rd1_rsp_valid(rd1_rsp_valid),
        .rd1_rsp_ready(rd1_rsp_ready),
        .rd1_rsp_data (rd1_rsp_data),
        .mem_raddr    (mem_raddr),
        .mem_raddr2   (mem_raddr2),
        .mem_rdata    (mem_rdata),
        .mem_rdata2   (mem_rdata2),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered read, old data on a same-edge write
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata  <= mem[mem_raddr];
        mem_rdata2 <= mem[mem_raddr2];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wr_valid      = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        rd0_req_valid = 1'b0;
        rd0_req_addr  = '0;
        rd0_rsp_ready = 1'b1;
        rd1_req_valid = 1'b0;
        rd1_req_addr  = '0;
        rd1_rsp_ready = 1'b1;
    endtask

    task automatic check_sweep(input string tag);
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_we got %b want 0", tag, mem_we);
        end
        // client requests during the sweep must be ignored
        wr_valid      = 1'b1;
        wr_addr       = 4'd9;
        wr_data       = 32'h0BAD_0BAD;
        rd0_req_valid = 1'b1;
        rd1_req_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (mem_we !== 1'b1 || mem_waddr !== AW'(k - 1)
                || mem_wdata !== INIT) begin
                errors++;
                $display("FAIL %s sweep%0d got we=%b a=%0d d=%h want 1 %0d %h",
                         tag, k, mem_we, mem_waddr, mem_wdata, k - 1, INIT);
            end
            checks++;
            if (init_done !== 1'b0 || wr_ready !== 1'b0
                || rd0_req_ready !== 1'b0 || rd1_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s early_ready%0d got %b%b%b%b want 0000", tag, k,
                         init_done, wr_ready, rd0_req_ready, rd1_req_ready);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (init_done !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL %s done17 got done=%b we=%b want 1 0",
                     tag, init_done, mem_we);
        end
        checks++;
        if (rd0_rsp_valid !== 1'b0 || rd1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s ignored_rsp got %b%b want 00",
                     tag, rd0_rsp_valid, rd1_rsp_valid);
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = INIT;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (init_done !== 1'b0 || mem_we !== 1'b0 || rd0_rsp_valid !== 1'b0
            || rd1_rsp_valid !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got done=%b we=%b v=%b%b wr=%b want 0",
                     init_done, mem_we, rd0_rsp_valid, rd1_rsp_valid, wr_ready);
        end
        tick();
        rst_n = 1'b1;
        check_sweep("init");
    endtask

    task automatic test_write_read;
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = 32'h1234_5678;
        exp_mem[3] = 32'h1234_5678;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_waddr !== 4'd3
            || mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wr_path got rdy=%b we=%b a=%0d d=%h", wr_ready,
                     mem_we, mem_waddr, mem_wdata);
        end
        tick();
        wr_valid      = 1'b0;
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 4'd3;
        rd1_req_valid = 1'b1;
        rd1_req_addr  = 4'd4;
        #1;
        checks++;
        if (rd0_req_ready !== 1'b1 || rd1_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_ready got %b%b want 11", rd0_req_ready, rd1_req_ready);
        end
        tick();
        rd0_req_valid = 1'b0;
        rd1_req_valid = 1'b0;
        #1;
        checks++;
        if (rd0_rsp_valid !== 1'b1 || rd0_rsp_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd0_a3 got v=%b d=%h want 1 12345678",
                     rd0_rsp_valid, rd0_rsp_data);
        end
        checks++;
        if (rd1_rsp_valid !== 1'b1 || rd1_rsp_data !== INIT) begin
            errors++;
            $display("FAIL rd1_a4 got v=%b d=%h want 1 %h",
                     rd1_rsp_valid, rd1_rsp_data, INIT);
        end
        tick();
        checks++;
        if (rd0_rsp_valid !== 1'b0 || rd1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_drop got %b%b want 00", rd0_rsp_valid, rd1_rsp_valid);
        end
    endtask

    task automatic test_forward;
        wr_valid      = 1'b1;
        wr_addr       = 4'd7;
        wr_data       = 32'hCAFE_F00D;
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 4'd7;
        exp_mem[7]    = 32'hCAFE_F00D;
        tick();
        wr_valid      = 1'b0;
        rd0_req_valid = 1'b0;
        #1;
        checks++;
        if (rd0_rsp_valid !== 1'b1 || rd0_rsp_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL forward got v=%b d=%h want 1 cafef00d",
                     rd0_rsp_valid, rd0_rsp_data);
        end
        tick();
    endtask

    task automatic test_backpressure;
        wr_valid = 1'b1;
        wr_addr  = 4'd5;
        wr_data  = 32'h0000_00A5;
        tick();
        wr_valid      = 1'b0;
        rd1_req_valid = 1'b1;
        rd1_req_addr  = 4'd5;
        rd1_rsp_ready = 1'b0;
        tick();
        rd1_req_valid = 1'b0;
        wr_valid      = 1'b1;
        wr_data       = 32'h0000_005A;
        exp_mem[5]    = 32'h0000_005A;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rd1_rsp_valid !== 1'b1 || rd1_rsp_data !== 32'h0000_00A5
                || rd1_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want 1 a5 0", c,
                         rd1_rsp_valid, rd1_rsp_data, rd1_req_ready);
            end
            tick();
            wr_valid = 1'b0;
        end
        rd1_rsp_ready = 1'b1;
        #1;
        checks++;
        if (rd1_rsp_valid !== 1'b1 || rd1_rsp_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL bp_release got v=%b d=%h want 1 a5",
                     rd1_rsp_valid, rd1_rsp_data);
        end
        tick();
        checks++;
        if (rd1_rsp_valid !== 1'b0 || rd1_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_consumed got v=%b rdy=%b want 0 1",
                     rd1_rsp_valid, rd1_req_ready);
        end
    endtask

    task automatic test_back_to_back;
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i <= 16; i++) begin
            rd0_req_valid = (i < 16);
            rd1_req_valid = (i < 16);
            rd0_req_addr  = AW'(i);
            rd1_req_addr  = AW'(15 - i);
            #1;
            if (i < 16) begin
                checks++;
                if (rd0_req_ready !== 1'b1 || rd1_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready%0d got %b%b want 11", i,
                             rd0_req_ready, rd1_req_ready);
                end
            end
            if (i == 0) begin
                checks++;
                if (rd0_rsp_valid !== 1'b0 || rd1_rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_start got %b%b want 00",
                             rd0_rsp_valid, rd1_rsp_valid);
                end
            end else begin
                if (rd0_rsp_valid === 1'b1) n0++;
                if (rd1_rsp_valid === 1'b1) n1++;
                checks++;
                if (rd0_rsp_valid !== 1'b1 || rd0_rsp_data !== exp_mem[i-1]) begin
                    errors++;
                    $display("FAIL b2b_rd0_%0d got v=%b d=%h want 1 %h", i - 1,
                             rd0_rsp_valid, rd0_rsp_data, exp_mem[i-1]);
                end
                checks++;
                if (rd1_rsp_valid !== 1'b1 || rd1_rsp_data !== exp_mem[16-i]) begin
                    errors++;
                    $display("FAIL b2b_rd1_%0d got v=%b d=%h want 1 %h", 16 - i,
                             rd1_rsp_valid, rd1_rsp_data, exp_mem[16-i]);
                end
            end
            tick();
        end
        checks++;
        if (n0 != 16 || n1 != 16 || rd0_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count got %0d %0d want 16 16", n0, n1);
        end
    endtask

    task automatic test_reset_mid;
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 4'd3;
        rd0_rsp_ready = 1'b0;
        tick();
        rd0_req_valid = 1'b0;
        tick();
        checks++;
        if (rd0_rsp_valid !== 1'b1 || rd0_rsp_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mid_held got v=%b d=%h want 1 12345678",
                     rd0_rsp_valid, rd0_rsp_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd0_rsp_valid !== 1'b0 || init_done !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b done=%b we=%b want 0 0 0",
                     rd0_rsp_valid, init_done, mem_we);
        end
        tick();
        rd0_rsp_ready = 1'b1;
        rst_n = 1'b1;
        check_sweep("reinit");
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 4'd3;
        tick();
        rd0_req_valid = 1'b0;
        #1;
        checks++;
        if (rd0_rsp_valid !== 1'b1 || rd0_rsp_data !== INIT) begin
            errors++;
            $display("FAIL reinit_read got v=%b d=%h want 1 %h",
                     rd0_rsp_valid, rd0_rsp_data, INIT);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'hBAD0_0000 | i;
            exp_mem[i] = INIT;
        end
        #12;
        test_reset();
        test_write_read();
        test_forward();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
